// File: rtl/tetris_board_renderer.sv
// ============================================================================
// Module   : tetris_board_renderer
// Purpose  : Double-buffered Tetris playfield with a combinational pixel path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tetris_board_renderer #(
   parameter int width_p     = 800,
   parameter int height_p    = 600,
   parameter int bit_depth_p = 8,
   parameter int cols_p      = 10,
   parameter int rows_p      = 20,
   parameter int cell_lg_p   = 4,
   parameter int x0_p        = 320,
   parameter int y0_p        = 140,
   parameter int border_p    = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [$clog2(width_p)-1:0]  x_i,
   input  logic [$clog2(height_p)-1:0] y_i,
   input  logic                        xy_v_i,
   output logic [bit_depth_p-1:0]      r_o,
   output logic [bit_depth_p-1:0]      g_o,
   output logic [bit_depth_p-1:0]      b_o,
   input  logic                        wr_v_i,
   output logic                        wr_ready_o,
   input  logic [$clog2(cols_p)-1:0]   wr_x_i,
   input  logic [$clog2(rows_p)-1:0]   wr_y_i,
   input  logic [2:0]                  wr_color_i,
   input  logic                        commit_i,
   input  logic [$clog2(cols_p)-1:0]   rd_x_i,
   input  logic [$clog2(rows_p)-1:0]   rd_y_i,
   output logic [2:0]                  rd_color_o,
   output logic                        frame_done_o
);

   localparam int ncells_lp  = cols_p * rows_p;
   localparam int iw_lp      = $clog2(ncells_lp);
   localparam int board_w_lp = cols_p << cell_lg_p;
   localparam int board_h_lp = rows_p << cell_lg_p;
   localparam int cell_mask_lp = (1 << cell_lg_p) - 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] COPY    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [2:0]        mem_q [2][ncells_lp];
   logic [2:0]        mem_d [2][ncells_lp];
   logic [iw_lp-1:0]  cnt_q, cnt_d;
   logic              front_sel_q, front_sel_d;
   logic              frame_done_q, frame_done_d;
   logic              back_sel;

   int                px, py, dx, dy;
   logic              frame_end;
   logic              in_board, in_frame, is_edge, dim;
   logic [iw_lp-1:0]  pix_idx, wr_idx, rd_idx;
   logic [2:0]        pix_code;
   logic [7:0]        r8, g8, b8;
   logic              wr_ok, rd_ok;

   function automatic logic [23:0] palette(input logic [2:0] code);
      case (code)
         3'd0:    palette = 24'h202020;
         3'd1:    palette = 24'h00FFFF;
         3'd2:    palette = 24'hFFFF00;
         3'd3:    palette = 24'h800080;
         3'd4:    palette = 24'h00FF00;
         3'd5:    palette = 24'hFF0000;
         3'd6:    palette = 24'h0000FF;
         default: palette = 24'hFF8000;
      endcase
   endfunction

   assign back_sel  = ~front_sel_q;
   assign px        = int'(x_i);
   assign py        = int'(y_i);
   assign dx        = px - x0_p;
   assign dy        = py - y0_p;
   assign frame_end = xy_v_i && (px == width_p - 1) && (py == height_p - 1);

   // Pixel path: pure combinational lookup into the front bank
   assign in_board = (dx >= 0) && (dx < board_w_lp) && (dy >= 0) && (dy < board_h_lp);
   assign in_frame = (dx >= -border_p) && (dx < board_w_lp + border_p) &&
                     (dy >= -border_p) && (dy < board_h_lp + border_p);
   assign pix_idx  = in_board ? iw_lp'((dy >>> cell_lg_p) * cols_p + (dx >>> cell_lg_p)) : '0;
   assign pix_code = mem_q[front_sel_q][pix_idx];
   assign is_edge  = ((dx & cell_mask_lp) == 0) || ((dy & cell_mask_lp) == 0);

   always_comb begin
      r8  = 8'h00;
      g8  = 8'h00;
      b8  = 8'h00;
      dim = 1'b0;
      if (xy_v_i) begin
         if (in_board) begin
            {r8, g8, b8} = palette(pix_code);
            dim = (pix_code != 3'd0) && is_edge;
         end else if (in_frame) begin
            {r8, g8, b8} = 24'h808080;
         end
      end
   end

   assign r_o = r8[7 -: bit_depth_p] >> dim;
   assign g_o = g8[7 -: bit_depth_p] >> dim;
   assign b_o = b8[7 -: bit_depth_p] >> dim;

   assign wr_ok  = (int'(wr_x_i) < cols_p) && (int'(wr_y_i) < rows_p);
   assign wr_idx = wr_ok ? iw_lp'(int'(wr_y_i) * cols_p + int'(wr_x_i)) : '0;
   assign rd_ok  = (int'(rd_x_i) < cols_p) && (int'(rd_y_i) < rows_p);
   assign rd_idx = rd_ok ? iw_lp'(int'(rd_y_i) * cols_p + int'(rd_x_i)) : '0;
   assign rd_color_o = rd_ok ? mem_q[back_sel][rd_idx] : 3'd0;

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit_i) state_d = PENDING;
         PENDING: if (frame_end) state_d = COPY;
         COPY:    if (cnt_q == iw_lp'(ncells_lp - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      wr_ready_o = (state_q == IDLE);
   end

   // Bank storage, swap and copy engine
   always_comb begin
      mem_d        = mem_q;
      cnt_d        = cnt_q;
      front_sel_d  = front_sel_q;
      frame_done_d = frame_end;
      case (state_q)
         IDLE: begin
            if (wr_v_i && wr_ok) mem_d[back_sel][wr_idx] = wr_color_i;
         end
         PENDING: begin
            if (frame_end) begin
               front_sel_d = ~front_sel_q;
               cnt_d       = '0;
            end
         end
         COPY: begin
            mem_d[back_sel][cnt_q] = mem_q[front_sel_q][cnt_q];
            cnt_d = cnt_q + iw_lp'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < ncells_lp; i++) begin
               mem_q[b][i] <= 3'd0;
            end
         end
         cnt_q        <= '0;
         front_sel_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         cnt_q        <= cnt_d;
         front_sel_q  <= front_sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign frame_done_o = frame_done_q;

endmodule

`default_nettype wire

// File: doc/tetris_board_renderer.md
Name: tetris_board_renderer

Overview:
- Pixel source that drives the VGA controller's r_i/g_i/b_i from its x_o/y_o/xy_v_o outputs.
- Holds the Tetris playfield (cols_p x rows_p cells, 3-bit colour code per cell) in a double-buffered register file.
- Game logic writes and reads the back bank; a commit swaps the banks at the frame boundary, then a copy engine refreshes the new back bank during blanking.

Parameters:
- width_p, 800, visible width in pixels
- height_p, 600, visible height in pixels
- bit_depth_p, 8, colour channel width (1..8)
- cols_p, 10, board columns
- rows_p, 20, board rows
- cell_lg_p, 4, log2 of cell size in pixels (cell = 16 px)
- x0_p, 320, board left edge, pixels
- y0_p, 140, board top edge, pixels
- border_p, 4, border band thickness, pixels

Ports:
- clk_i  in  1  pixel clock
- reset_n_i  in  1  asynchronous, active-low reset
- x_i  in  $clog2(width_p)  pixel x from the VGA controller
- y_i  in  $clog2(height_p)  pixel y from the VGA controller
- xy_v_i  in  1  pixel coordinate valid
- r_o, g_o, b_o  out  bit_depth_p each  pixel colour
- wr_v_i  in  1  cell write valid
- wr_ready_o  out  1  write/commit accept
- wr_x_i  in  $clog2(cols_p)  write column
- wr_y_i  in  $clog2(rows_p)  write row
- wr_color_i  in  3  write colour code
- commit_i  in  1  request bank swap
- rd_x_i  in  $clog2(cols_p)  back-bank read column
- rd_y_i  in  $clog2(rows_p)  back-bank read row
- rd_color_o  out  3  back-bank cell, combinational
- frame_done_o  out  1  one-cycle pulse at each frame end

Behaviour:
- Reset (async, reset_n_i=0): both banks all 0, front_sel=0, FSM=IDLE, copy counter 0, frame_done_o=0, wr_ready_o=1 (IDLE). r/g/b are combinational and follow the pixel rules (0 while xy_v_i=0).
- Pixel path: zero added latency; r/g/b are a combinational function of x_i, y_i, xy_v_i and the front bank.
  - xy_v_i=0 -> 0,0,0.
  - Board rect, x0_p <= x < x0_p+cols_p<<cell_lg_p, same for y with rows_p: cell = ((x-x0_p)>>cell_lg_p, (y-y0_p)>>cell_lg_p), colour = palette[front[cell]].
  - If the cell is nonzero and the low cell_lg_p bits of (x-x0_p) or (y-y0_p) are 0 (edge pixel), each channel is shifted right by 1.
  - Within border_p px outside the board rect -> 0x80 grey.
  - Else 0,0,0.
- Palette (8-bit values; take the top bit_depth_p bits): 0=20,20,20; 1=00,FF,FF; 2=FF,FF,00; 3=80,00,80; 4=00,FF,00; 5=FF,00,00; 6=00,00,FF; 7=FF,80,00.
- Frame end: the cycle with xy_v_i=1, x_i=width_p-1, y_i=height_p-1. frame_done_o=1 on the following cycle only, every frame, in every state.
- FSM states and transitions:
  - IDLE: wr_ready_o=1.
    - wr_v_i=1 writes back bank at the edge.
    - commit_i=1 -> PENDING.
    - Write and commit in the same cycle: the write lands first, then PENDING.
  - PENDING: wr_ready_o=0; wr_v_i and commit_i are ignored.
    - At the frame-end edge: front_sel toggles (new front visible from the next frame's first pixel) -> COPY, counter=0.
  - COPY: wr_ready_o=0. Each cycle back[counter] <= front[counter], counter +1. After entry cols_p*rows_p-1 -> IDLE (copy takes 200 cycles at defaults, well inside vertical blanking).
- Writes with wr_x_i>=cols_p or wr_y_i>=rows_p are dropped silently; commit still accepted.
- rd_color_o reads the back bank combinationally; out-of-range address returns 0. Reads during COPY return the partially copied contents.
- commit_i while not IDLE is dropped (no queueing).
- Reset asserted mid-COPY or mid-PENDING: immediate return to the reset state; the pending swap is lost.

Test Plan:
- Reset, then scan a full frame -> every board pixel = 20,20,20 (edge pixels 10,10,10 not applied since cells are 0); border pixel (316,140) = 80,80,80; (0,0) = 0; frame_done_o pulses once, 1 cycle after (799,599).
- Write (3,5)=5, commit mid-frame -> wr_ready_o=0 immediately; current frame still shows 20,20,20 at (376,228); swap at frame end; next frame (376,228)=FF,00,00 and edge pixel (368,228)=7F,00,00.
- After the swap, count cycles -> wr_ready_o returns to 1 exactly 200 cycles after the swap edge; rd_color_o at (3,5) = 5.
- Write (12,3) and (2,25) -> dropped; rd_color_o for neighbouring cells unchanged; wr_ready_o stays 1.
- Same-cycle wr_v_i + commit_i in IDLE -> the write is included in the swapped frame; a second commit during PENDING is ignored (exactly one swap).
- Assert reset_n_i during COPY -> outputs and state return to reset values asynchronously; the displayed board reverts to all empty.
